// File: rtl/mul_issue_ctrl_pkg.sv
// Shared types and constants for the EX-stage multiply issue controller.
package mul_issue_ctrl_pkg;

   // Controller state encodings
   typedef enum logic [1:0] {
      MulCtrlIdle  = 2'b00,
      MulCtrlBusy  = 2'b01,
      MulCtrlDone  = 2'b10,
      MulCtrlDrain = 2'b11
   } mul_ctrl_state_e;

   // mymul handshake levels
   localparam logic        MulStart       = 1'b1;
   localparam logic        MulStop        = 1'b0;
   localparam logic        MulResultReady = 1'b1;
   localparam logic [31:0] ZeroWord       = 32'h0000_0000;

   // Drain counter width; wide enough for any sensible FLUSH_DRAIN
   localparam int DrainCntW = 8;

   // Upper half of a 64-bit product
   function automatic logic [31:0] prod_hi(input logic [63:0] prod);
      return prod[63:32];
   endfunction

   // Lower half of a 64-bit product
   function automatic logic [31:0] prod_lo(input logic [63:0] prod);
      return prod[31:0];
   endfunction

endpackage

// File: rtl/mul_issue_ctrl.sv
// Initiator side of the mymul start/annul/ready handshake: latches operands,
// stalls EX while the multiply runs, writes hi/lo once, and drains on flush.
module mul_issue_ctrl
   import mul_issue_ctrl_pkg::*;
#(
   parameter int FLUSH_DRAIN = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mul_req_i,
   input  logic        mul_signed_i,
   input  logic [31:0] op1_i,
   input  logic [31:0] op2_i,
   input  logic        flush_i,
   output logic        stall_o,
   output logic        hilo_we_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        mul_start_o,
   output logic        mul_annul_o,
   output logic        mul_signed_o,
   output logic [31:0] mul_op1_o,
   output logic [31:0] mul_op2_o,
   input  logic [63:0] mul_result_i,
   input  logic        mul_ready_i
);

   mul_ctrl_state_e        r_state;
   mul_ctrl_state_e        w_next_state;
   logic [31:0]            r_op1;
   logic [31:0]            r_op2;
   logic                   r_signed;
   logic [31:0]            r_hi;
   logic [31:0]            r_lo;
   logic [DrainCntW-1:0]   r_drain_cnt;
   logic                   w_issue;
   logic                   w_capture;
   logic                   w_load_drain;

   // Next-state and handshake/output decode; operands stay on the holding regs
   // except in the issue cycle, where mymul sees the EX operands directly.
   always_comb begin
      w_next_state = r_state;
      w_issue      = 1'b0;
      w_capture    = 1'b0;
      w_load_drain = 1'b0;
      stall_o      = 1'b0;
      hilo_we_o    = 1'b0;
      mul_start_o  = MulStop;
      mul_annul_o  = 1'b0;
      mul_signed_o = r_signed;
      mul_op1_o    = r_op1;
      mul_op2_o    = r_op2;
      case (r_state)
         MulCtrlIdle: begin
            if (mul_req_i && !flush_i) begin
               w_issue      = 1'b1;
               stall_o      = 1'b1;
               mul_start_o  = MulStart;
               mul_signed_o = mul_signed_i;
               mul_op1_o    = op1_i;
               mul_op2_o    = op2_i;
               w_next_state = MulCtrlBusy;
            end else begin
               w_next_state = MulCtrlIdle;
            end
         end
         MulCtrlBusy: begin
            // Flush wins over a coincident ready: the result is dropped
            if (flush_i) begin
               mul_annul_o  = 1'b1;
               w_load_drain = 1'b1;
               w_next_state = MulCtrlDrain;
            end else begin
               stall_o     = 1'b1;
               mul_start_o = MulStart;
               if (mul_ready_i == MulResultReady) begin
                  w_capture    = 1'b1;
                  w_next_state = MulCtrlDone;
               end else begin
                  w_next_state = MulCtrlBusy;
               end
            end
         end
         MulCtrlDone: begin
            // Same instruction is still in EX, so a request here is not new
            hilo_we_o    = !flush_i;
            w_next_state = MulCtrlIdle;
         end
         MulCtrlDrain: begin
            // Hold annul so a late zero-path completion cannot leak into a new issue
            mul_annul_o = 1'b1;
            if (r_drain_cnt == '0) begin
               w_next_state = MulCtrlIdle;
            end else begin
               w_next_state = MulCtrlDrain;
            end
         end
         default: begin
            w_next_state = MulCtrlIdle;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= MulCtrlIdle;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Operand holding registers, loaded on issue and stable until the next one
   always_ff @(posedge clk) begin
      if (rst) begin
         r_op1    <= ZeroWord;
         r_op2    <= ZeroWord;
         r_signed <= 1'b0;
      end else if (w_issue) begin
         r_op1    <= op1_i;
         r_op2    <= op2_i;
         r_signed <= mul_signed_i;
      end
   end

   // hi/lo result registers, updated only when mymul reports ready
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hi <= ZeroWord;
         r_lo <= ZeroWord;
      end else if (w_capture) begin
         r_hi <= prod_hi(mul_result_i);
         r_lo <= prod_lo(mul_result_i);
      end
   end

   // Drain down-counter: loaded on cancel, counts down while draining
   always_ff @(posedge clk) begin
      if (rst) begin
         r_drain_cnt <= '0;
      end else if (w_load_drain) begin
         r_drain_cnt <= DrainCntW'(FLUSH_DRAIN - 1);
      end else if (r_state == MulCtrlDrain && r_drain_cnt != '0) begin
         r_drain_cnt <= r_drain_cnt - 1'b1;
      end
   end

   assign hi_o = r_hi;
   assign lo_o = r_lo;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Scoreboard bench for mul_issue_ctrl with a cycle-accurate mymul stand-in.
module tb_mul_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        mul_req_i, mul_signed_i, flush_i;
   logic [31:0] op1_i, op2_i;
   logic        stall_o, hilo_we_o, mul_start_o, mul_annul_o, mul_signed_o;
   logic [31:0] hi_o, lo_o, mul_op1_o, mul_op2_o;
   logic [63:0] mul_result_i;
   logic        mul_ready_i;

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } exp_t;
   exp_t sbq[$];

   mul_issue_ctrl #(.FLUSH_DRAIN(2)) dut (
      .clk(clk), .rst(rst), .mul_req_i(mul_req_i), .mul_signed_i(mul_signed_i),
      .op1_i(op1_i), .op2_i(op2_i), .flush_i(flush_i), .stall_o(stall_o),
      .hilo_we_o(hilo_we_o), .hi_o(hi_o), .lo_o(lo_o), .mul_start_o(mul_start_o),
      .mul_annul_o(mul_annul_o), .mul_signed_o(mul_signed_o), .mul_op1_o(mul_op1_o),
      .mul_op2_o(mul_op2_o), .mul_result_i(mul_result_i), .mul_ready_i(mul_ready_i)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   // mymul stand-in: ready 35 cycles after start, or 3 if an operand is zero
   logic [5:0] m_cnt;
   logic       m_zero;
   logic signed [63:0] m_sprod;
   always @(posedge clk) begin
      if (rst || !mul_start_o || mul_annul_o) m_cnt <= 6'd0;
      else m_cnt <= m_cnt + 6'd1;
   end
   assign m_zero      = (mul_op1_o == 32'd0) || (mul_op2_o == 32'd0);
   assign mul_ready_i = mul_start_o && !mul_annul_o && (m_cnt == (m_zero ? 6'd3 : 6'd35));
   assign m_sprod     = $signed({{32{mul_op1_o[31]}}, mul_op1_o}) * $signed({{32{mul_op2_o[31]}}, mul_op2_o});
   assign mul_result_i = mul_signed_o ? 64'(m_sprod) : ({32'd0, mul_op1_o} * {32'd0, mul_op2_o});

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      else n_pass++;
   endtask

   // Monitor: every hi/lo write must match the oldest expected product and cycle
   always @(negedge clk) begin
      #2;
      if (hilo_we_o === 1'b1) begin
         if (sbq.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_write: got hi=%0h lo=%0h, expected no write (cycle %0d)", hi_o, lo_o, cyc);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("sb_hi", hi_o, e.hi);
            chk("sb_lo", lo_o, e.lo);
            chk("sb_cycle", cyc, e.cyc);
         end
      end
   end

   // Issue one multiply and follow it to its write, checking stall and operand hold
   task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input logic [31:0] ehi, input logic [31:0] elo, input int lat,
                          input bit chg, output int issue_c, output int done_c);
      int n_stall;
      bit got;
      bit op_ok;
      @(negedge clk);
      op1_i = a; op2_i = b; mul_signed_i = sgn; mul_req_i = 1'b1;
      #1;
      issue_c = cyc;
      chk("issue_stall", stall_o, 1);
      chk("issue_start", mul_start_o, 1);
      chk("issue_op1", mul_op1_o, a);
      sbq.push_back('{hi: ehi, lo: elo, cyc: cyc + lat});
      n_stall = 1; got = 1'b0; op_ok = 1'b1; done_c = -1;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         mul_req_i = 1'b0;
         if (chg) begin op1_i = ~a; op2_i = 32'h1234_5678; end
         #1;
         if (hilo_we_o) begin
            got = 1'b1; done_c = cyc;
         end else begin
            if (stall_o) n_stall++;
            if (mul_op1_o !== a || mul_op2_o !== b || mul_signed_o !== sgn || mul_start_o !== 1'b1) op_ok = 1'b0;
         end
      end
      chk("done_seen", got, 1);
      chk("stall_cycles", n_stall, lat);
      chk("busy_ops_hold", op_ok, 1);
   endtask

   // Bounded wait for the next hi/lo write
   task automatic wait_we(input string name);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         mul_req_i = 1'b0;
         #1;
         if (hilo_we_o) got = 1'b1;
      end
      chk(name, got, 1);
   endtask

   initial begin
      int ic, dc, ic2, dc2;
      rst = 1'b1; mul_req_i = 1'b0; mul_signed_i = 1'b0; flush_i = 1'b0;
      op1_i = 32'd0; op2_i = 32'd0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_stall", stall_o, 0);
      chk("rst_we", hilo_we_o, 0);
      chk("rst_hi", hi_o, 0);
      chk("rst_lo", lo_o, 0);
      chk("rst_start", mul_start_o, 0);
      chk("rst_annul", mul_annul_o, 0);
      chk("rst_ops", {mul_op1_o, mul_op2_o}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Signed -3 * 7, unsigned max*max with operands wiggling, zero operand
      run_mul(32'hFFFF_FFFD, 32'd7, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 36, 1'b0, ic, dc);
      run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001, 36, 1'b1, ic, dc);
      run_mul(32'd0, 32'd5, 1'b0, 32'd0, 32'd0, 4, 1'b0, ic, dc);
      chk("zero_lat_done", dc - ic, 4);

      // Flush in cycle 10 of a long multiply, then 6*7 held until accepted
      @(negedge clk);
      op1_i = 32'd9; op2_i = 32'd9; mul_signed_i = 1'b0; mul_req_i = 1'b1;
      #1;
      chk("f_issue_stall", stall_o, 1);
      repeat (9) begin @(negedge clk); mul_req_i = 1'b0; end
      @(negedge clk);
      flush_i = 1'b1;
      #1;
      chk("f_annul", mul_annul_o, 1);
      chk("f_stall", stall_o, 0);
      chk("f_start", mul_start_o, 0);
      chk("f_we", hilo_we_o, 0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         flush_i = 1'b0; mul_req_i = 1'b1; op1_i = 32'd6; op2_i = 32'd7;
         #1;
         chk("drain_annul", mul_annul_o, 1);
         chk("drain_stall", stall_o, 0);
         chk("drain_start", mul_start_o, 0);
      end
      @(negedge clk);
      #1;
      chk("post_drain_stall", stall_o, 1);
      chk("post_drain_start", mul_start_o, 1);
      sbq.push_back('{hi: 32'd0, lo: 32'd42, cyc: cyc + 36});
      wait_we("f_new_done");

      // Flush coinciding with ready of a zero-operand multiply
      @(negedge clk);
      op1_i = 32'd0; op2_i = 32'd5; mul_req_i = 1'b1;
      repeat (2) begin @(negedge clk); mul_req_i = 1'b0; end
      @(negedge clk);
      flush_i = 1'b1;
      #1;
      chk("zf_annul", mul_annul_o, 1);
      chk("zf_stall", stall_o, 0);
      chk("zf_we", hilo_we_o, 0);
      @(negedge clk);
      flush_i = 1'b0;
      #1;
      chk("zf_drain1", mul_annul_o, 1);
      @(negedge clk);
      #1;
      chk("zf_drain2", mul_annul_o, 1);
      run_mul(32'd2, 32'd3, 1'b0, 32'd0, 32'd6, 36, 1'b0, ic, dc);

      // Back-to-back issue straight after DONE
      run_mul(32'd3, 32'd4, 1'b0, 32'd0, 32'd12, 36, 1'b0, ic, dc);
      run_mul(32'd5, 32'd6, 1'b0, 32'd0, 32'd30, 36, 1'b0, ic2, dc2);
      chk("b2b_gap", ic2 - dc, 1);

      // Flush with a request in IDLE: no issue, no stall
      @(negedge clk);
      op1_i = 32'd1; op2_i = 32'd1; mul_req_i = 1'b1; flush_i = 1'b1;
      #1;
      chk("idle_flush_stall", stall_o, 0);
      chk("idle_flush_start", mul_start_o, 0);
      @(negedge clk);
      mul_req_i = 1'b0; flush_i = 1'b0;
      #1;
      chk("idle_flush_noissue", mul_start_o, 0);

      repeat (5) @(negedge clk);
      #3;
      chk("sb_empty", sbq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mul_issue_ctrl.md
# mul_issue_ctrl

EX-stage controller that owns the initiator side of the `mymul` start/annul/ready handshake. Accepts a multiply request from the EX pipeline, latches and holds the operands, and drives `mymul` until its result is ready. Stalls the pipeline while the multiply is in flight, delivers the 64-bit product as a one-cycle hi/lo write, and cancels cleanly on pipeline flush. Sits between EX decode and `mymul`; both are instantiated side by side in the EX stage.

## Interface
Parameters:
- FLUSH_DRAIN, 2, cycles `start_o`/`annul_o` are held after a cancel before a new issue is allowed (≥2; covers `mymul` MulByZero→MulEnd→MulFree)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- mul_req_i  in  1  EX holds a mult/multu instruction
- mul_signed_i  in  1  1 = mult (signed), 0 = multu
- op1_i  in  32  multiplicand from EX
- op2_i  in  32  multiplier from EX
- flush_i  in  1  pipeline flush; kills the in-flight multiply
- stall_o  out  1  stall request to pipeline control
- hilo_we_o  out  1  one-cycle hi/lo write strobe
- hi_o  out  32  product[63:32]
- lo_o  out  32  product[31:0]
- mul_start_o  out  1  to `mymul` start_i (`MulStart`/`MulStop`)
- mul_annul_o  out  1  to `mymul` annul_i
- mul_signed_o  out  1  to `mymul` signed_mul_i
- mul_op1_o  out  32  to `mymul` opdata1_i
- mul_op2_o  out  32  to `mymul` opdata2_i
- mul_result_i  in  64  from `mymul` result_o
- mul_ready_i  in  1  from `mymul` ready_o

## Operation
States: IDLE, BUSY, DONE, DRAIN.
- IDLE: `mul_start_o`=0. On `mul_req_i`=1 and `flush_i`=0: latch op1/op2/signed into holding regs, drive `mul_start_o`=1 with op1/op2/signed taken combinationally from the inputs that cycle, `stall_o`=1, next BUSY. `mul_ready_i` is ignored in IDLE.
- BUSY: `mul_start_o`=1; `mul_op*_o`/`mul_signed_o` come from the holding regs and stay stable (`mymul` re-reads op signs at completion). `stall_o`=1.
  - `flush_i`=1 → `mul_annul_o`=1, `mul_start_o`=0, next DRAIN. Flush takes priority over `mul_ready_i`.
  - `mul_ready_i`=1 → capture `mul_result_i` into hi/lo regs, next DONE.
- DONE: `mul_start_o`=0 (releases `mymul` to MulFree), `stall_o`=0, `hilo_we_o`=1 unless `flush_i`=1 (product discarded). Always next IDLE. `mul_req_i` is ignored in DONE, because the same instruction is still in EX.
- DRAIN: `mul_start_o`=0, `mul_annul_o`=1, `stall_o`=0. Down-counter loaded with FLUSH_DRAIN−1; next IDLE when it reaches 0. `mul_req_i` is not accepted, so stale `mymul` completions (ByZero path) cannot raise ready into a new issue.
- Width rules: hi/lo come straight from the 64-bit product; no sign handling here (`mymul` does it).

## Timing
- Reset values:
  - state IDLE, all outputs 0
  - hi/lo regs 0
  - holding regs 0
  - drain counter 0
- `stall_o` is combinational: it rises in the same cycle `mul_req_i` is seen in IDLE.
- Latency with a `mymul` partner, issue cycle = 0:
  - nonzero operands: `mul_ready_i` is seen in cycle 35; DONE (`hilo_we_o`) is cycle 36; pipeline stalled cycles 0–35.
  - either operand zero: ready in cycle 3, DONE in cycle 4.
- `hilo_we_o` is exactly one cycle per completed, unflushed multiply. hi/lo are valid in that cycle and hold until the next capture.
- Back-to-back: the next request is accepted in the IDLE cycle after DONE, with no bubble beyond that.
- A flush in IDLE with a request means no issue, no stall.
- Reset mid-operation returns to IDLE. `mymul` shares `rst`, so no drain is needed.

## Structure
- Add to `defines.vh`:
  - state encodings `MulCtrlIdle`, `MulCtrlBusy`, `MulCtrlDone`, `MulCtrlDrain` (2 bits)
- Reuse the existing constants `MulStart`, `MulStop`, `MulResultReady` and `ZeroWord`.
- No sub-module: one state machine plus holding/result registers. `mymul` is instantiated beside it in EX, not inside it.

## Test plan
- Signed `mymul`: op1=0xFFFFFFFD (−3), op2=7 → stall for cycles 0–35, `hilo_we_o` in cycle 36, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- Unsigned: op1=0xFFFFFFFF, op2=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. `mul_op*_o` stays constant throughout BUSY even if op1_i/op2_i change.
- Zero operand: op1=0, op2=5 → `hilo_we_o` in cycle 4, hi=lo=0.
- Flush in cycle 10 of BUSY:
  - `mul_annul_o`=1 and `stall_o`=0 from cycle 10, DRAIN for 2 cycles, no `hilo_we_o`
  - a new request (6×7) immediately after is accepted once IDLE is reached → lo=42.
- Flush in the ready cycle of a zero-operand multiply → DRAIN, no write. The following request (2×3) yields lo=6 with no stale zero result.
- Back-to-back requests (3×4 then 5×6) → two `hilo_we_o` pulses with lo=12 then 30, and exactly one IDLE cycle between DONE and the second issue.
